// File: rtl/expand_view_challenge_rs.sv
// ExpandViewChallenge: streams h2 to the hash core, then rejection-samples the squeezed
// words into TAU challenge indices below N_PARTIES, with a squeeze budget and failure flag.
module expand_view_challenge_rs #(
    parameter int SEED_SIZE = 128,
    parameter int TAU       = 17,
    parameter int WORD_W    = 32,
    parameter int ELEM_BITS = 8,
    parameter int N_PARTIES = 256,
    parameter int MAX_WORDS = 64,
    localparam int H2_WORDS = 2 * SEED_SIZE / 32,
    localparam int H2_AW    = (H2_WORDS > 1) ? $clog2(H2_WORDS) : 1,
    localparam int IS_AW    = (TAU > 1) ? $clog2(TAU) : 1,
    localparam int WU_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_done,
    output logic                 o_fail,
    input  logic [31:0]          i_h2,
    input  logic [H2_AW-1:0]     i_h2_addr,
    input  logic                 i_h2_wr_en,
    output logic [31:0]          o_hash_data_in,
    input  logic [H2_AW-1:0]     i_hash_addr,
    input  logic                 i_hash_rd_en,
    input  logic [WORD_W-1:0]    i_hash_data_out,
    input  logic                 i_hash_data_out_valid,
    output logic                 o_hash_data_out_ready,
    output logic [31:0]          o_hash_input_length,
    output logic [31:0]          o_hash_output_length,
    output logic                 o_hash_start,
    output logic                 o_hash_force_done,
    input  logic                 i_hash_force_done_ack,
    output logic [ELEM_BITS-1:0] o_i_star,
    input  logic [IS_AW-1:0]     i_i_star_addr,
    input  logic                 i_i_star_rd_en,
    output logic [WU_W-1:0]      o_words_used
);

    localparam int E     = WORD_W / ELEM_BITS;
    localparam int EI_W  = (E > 1) ? $clog2(E) : 1;
    localparam int CNT_W = $clog2(TAU + 1);
    localparam logic [31:0] NP_BOUND = 32'(N_PARTIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXTRACT,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WU_W-1:0]     words_q, words_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic [EI_W-1:0]     idx_q, idx_d;
    logic                fail_q, fail_d;
    logic                hstart_q, hstart_d;
    logic [31:0]         hdin_q;
    logic [ELEM_BITS-1:0] istar_q;

    logic [ELEM_BITS-1:0] cand;
    logic                 accept;
    logic                 last_cand;
    logic                 is_we;
    logic                 busy;
    logic [IS_AW-1:0]     is_addr;
    logic [H2_AW-1:0]     h2_addr;

    logic [31:0]          h2_mem [H2_WORDS];
    logic [ELEM_BITS-1:0] is_mem [TAU];

    assign cand      = sreg_q[WORD_W-1 -: ELEM_BITS];
    assign accept    = 32'(cand) < NP_BOUND;
    assign last_cand = idx_q == EI_W'(E - 1);
    assign busy      = state_q != ST_IDLE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            words_q  <= '0;
            sreg_q   <= '0;
            idx_q    <= '0;
            fail_q   <= 1'b0;
            hstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            words_q  <= words_d;
            sreg_q   <= sreg_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            hstart_q <= hstart_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        words_d               = words_q;
        sreg_d                = sreg_q;
        idx_d                 = idx_q;
        fail_d                = fail_q;
        hstart_d              = 1'b0;
        is_we                 = 1'b0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        o_done                = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    hstart_d = 1'b1;
                    fail_d   = 1'b0;
                    words_d  = '0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_hash_data_out_ready = 1'b1;
                if (i_hash_data_out_valid) begin
                    sreg_d  = i_hash_data_out;
                    words_d = words_q + WU_W'(1);
                    idx_d   = '0;
                    state_d = ST_EXTRACT;
                end
            end
            ST_EXTRACT: begin
                if (accept) begin
                    is_we = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                sreg_d = sreg_q << ELEM_BITS;
                idx_d  = idx_q + EI_W'(1);
                // Reaching TAU wins over budget exhaustion on the same candidate.
                if (accept && (cnt_q == CNT_W'(TAU - 1))) begin
                    state_d = ST_FLUSH;
                end else if (last_cand) begin
                    if (words_q == WU_W'(MAX_WORDS)) begin
                        fail_d  = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_FLUSH: begin
                o_hash_force_done = 1'b1;
                if (i_hash_force_done_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // h2 store: a single port shared between user writes and hash-core reads.
    assign h2_addr = i_h2_wr_en ? i_h2_addr : i_hash_addr;

    always_ff @(posedge i_clk) begin
        if (i_h2_wr_en) begin
            h2_mem[h2_addr] <= i_h2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hdin_q <= '0;
        end else if (!i_h2_wr_en && i_hash_rd_en) begin
            hdin_q <= h2_mem[h2_addr];
        end
    end

    // i_star store: internal write address owns the port whenever a run is in flight.
    assign is_addr = busy ? cnt_q[IS_AW-1:0] : i_i_star_addr;

    always_ff @(posedge i_clk) begin
        if (is_we) begin
            is_mem[is_addr] <= cand;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            istar_q <= '0;
        end else if (i_i_star_rd_en) begin
            istar_q <= is_mem[is_addr];
        end
    end

    assign o_fail               = fail_q;
    assign o_hash_start         = hstart_q;
    assign o_words_used         = words_q;
    assign o_hash_data_in       = hdin_q;
    assign o_i_star             = istar_q;
    assign o_hash_input_length  = 32'(2 * SEED_SIZE);
    assign o_hash_output_length = 32'(MAX_WORDS * WORD_W);

endmodule

// File: tb/tb_expand_view_challenge_rs.sv
// Directed bench for expand_view_challenge_rs across three parameterisations sharing one
// stimulus harness; a scoreboard queue holds the i_star values the reference predicts.
module tb_expand_view_challenge_rs;

    localparam int CF_WW  [3] = '{32, 32, 64};
    localparam int CF_EB  [3] = '{8, 8, 16};
    localparam int CF_NP  [3] = '{256, 200, 1000};
    localparam int CF_TAU [3] = '{17, 17, 4};
    localparam int CF_MW  [3] = '{64, 4, 4};

    typedef struct {
        int addr;
        int val;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst, start, h2_we, hash_rd, hvalid, ack, is_rd;
    logic [31:0] h2;
    logic [2:0]  h2_addr, hash_addr;
    logic [63:0] hdata;
    logic [4:0]  is_addr;
    logic [1:0]  sel;

    logic        a_done, a_fail, a_ready, a_hstart, a_force;
    logic [31:0] a_hdin, a_inlen, a_outlen;
    logic [7:0]  a_istar;
    logic [6:0]  a_words;
    logic        b_done, b_fail, b_ready, b_hstart, b_force;
    logic [31:0] b_hdin, b_inlen, b_outlen;
    logic [7:0]  b_istar;
    logic [2:0]  b_words;
    logic        c_done, c_fail, c_ready, c_hstart, c_force;
    logic [31:0] c_hdin, c_inlen, c_outlen;
    logic [15:0] c_istar;
    logic [2:0]  c_words;

    logic        m_done, m_fail, m_ready, m_hstart, m_force;
    logic [31:0] m_hdin;
    logic [15:0] m_istar;
    logic [6:0]  m_words;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          last_lat;
    logic [63:0] wq [$];
    sb_t         sb_q [$];
    int          mm [3][17];
    logic [31:0] h2_ref [8];

    always #5 clk = ~clk;

    expand_view_challenge_rs u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 2'd0),
        .o_done(a_done), .o_fail(a_fail),
        .i_h2(h2), .i_h2_addr(h2_addr), .i_h2_wr_en(h2_we),
        .o_hash_data_in(a_hdin), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd),
        .i_hash_data_out(hdata[31:0]), .i_hash_data_out_valid(hvalid && sel == 2'd0),
        .o_hash_data_out_ready(a_ready), .o_hash_input_length(a_inlen),
        .o_hash_output_length(a_outlen), .o_hash_start(a_hstart),
        .o_hash_force_done(a_force), .i_hash_force_done_ack(ack && sel == 2'd0),
        .o_i_star(a_istar), .i_i_star_addr(is_addr), .i_i_star_rd_en(is_rd),
        .o_words_used(a_words)
    );

    expand_view_challenge_rs #(.N_PARTIES(200), .MAX_WORDS(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 2'd1),
        .o_done(b_done), .o_fail(b_fail),
        .i_h2(h2), .i_h2_addr(h2_addr), .i_h2_wr_en(h2_we),
        .o_hash_data_in(b_hdin), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd),
        .i_hash_data_out(hdata[31:0]), .i_hash_data_out_valid(hvalid && sel == 2'd1),
        .o_hash_data_out_ready(b_ready), .o_hash_input_length(b_inlen),
        .o_hash_output_length(b_outlen), .o_hash_start(b_hstart),
        .o_hash_force_done(b_force), .i_hash_force_done_ack(ack && sel == 2'd1),
        .o_i_star(b_istar), .i_i_star_addr(is_addr), .i_i_star_rd_en(is_rd),
        .o_words_used(b_words)
    );

    expand_view_challenge_rs #(.WORD_W(64), .ELEM_BITS(16), .N_PARTIES(1000), .TAU(4),
                               .MAX_WORDS(4)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start && sel == 2'd2),
        .o_done(c_done), .o_fail(c_fail),
        .i_h2(h2), .i_h2_addr(h2_addr), .i_h2_wr_en(h2_we),
        .o_hash_data_in(c_hdin), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd),
        .i_hash_data_out(hdata), .i_hash_data_out_valid(hvalid && sel == 2'd2),
        .o_hash_data_out_ready(c_ready), .o_hash_input_length(c_inlen),
        .o_hash_output_length(c_outlen), .o_hash_start(c_hstart),
        .o_hash_force_done(c_force), .i_hash_force_done_ack(ack && sel == 2'd2),
        .o_i_star(c_istar), .i_i_star_addr(is_addr[1:0]), .i_i_star_rd_en(is_rd),
        .o_words_used(c_words)
    );

    always_comb begin
        m_done = a_done; m_fail = a_fail; m_ready = a_ready; m_hstart = a_hstart;
        m_force = a_force; m_hdin = a_hdin; m_istar = {8'h00, a_istar}; m_words = a_words;
        if (sel == 2'd1) begin
            m_done = b_done; m_fail = b_fail; m_ready = b_ready; m_hstart = b_hstart;
            m_force = b_force; m_hdin = b_hdin; m_istar = {8'h00, b_istar};
            m_words = {4'b0, b_words};
        end else if (sel == 2'd2) begin
            m_done = c_done; m_fail = c_fail; m_ready = c_ready; m_hstart = c_hstart;
            m_force = c_force; m_hdin = c_hdin; m_istar = c_istar;
            m_words = {4'b0, c_words};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_istar(input int a, output logic [15:0] v);
        @(negedge clk);
        is_addr = 5'(a);
        is_rd   = 1'b1;
        @(negedge clk);
        is_rd = 1'b0;
        v     = m_istar;
    endtask

    // Reference model computed up front from the word list; the DUT then runs against it.
    task automatic run(input int c, input bit toggle, input int ack_dly, input bit dbl_start,
                       input string tag);
        int ww, eb, e, acc, used, idx, fcnt, hs_cnt, ready_bad, t_hs;
        bit exp_fail, got_done;
        longint cand, mask;
        ww = CF_WW[c]; eb = CF_EB[c]; e = ww / eb;
        mask = (longint'(1) << eb) - 1;
        acc = 0; used = 0;
        for (int w = 0; w < wq.size() && acc < CF_TAU[c] && used < CF_MW[c]; w++) begin
            used++;
            for (int k = 0; k < e && acc < CF_TAU[c]; k++) begin
                cand = longint'(wq[w] >> (ww - eb * (k + 1))) & mask;
                if (cand < CF_NP[c]) begin
                    sb_q.push_back(sb_t'{acc, int'(cand)});
                    mm[c][acc] = int'(cand);
                    acc++;
                end
            end
        end
        exp_fail = acc < CF_TAU[c];

        sel = 2'(c);
        idx = 0; fcnt = 0; hs_cnt = 0; ready_bad = 0; t_hs = 0; got_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = dbl_start && cyc == 8;
            if (m_hstart) begin hs_cnt++; t_hs = cyc; end
            if (m_force) fcnt++;
            if (m_ready && m_force) ready_bad++;
            if (m_done) begin
                got_done = 1'b1;
                last_lat = cyc - t_hs;
                check({tag, "_fail"}, m_fail, exp_fail);
                check({tag, "_words"}, m_words, used);
                break;
            end
            ack    = m_force && (fcnt >= ack_dly);
            hvalid = (idx < wq.size()) && (!toggle || cyc % 2 == 0);
            hdata  = hvalid ? wq[idx] : '0;
            if (hvalid && m_ready) idx++;
        end
        start = 1'b0; hvalid = 1'b0; ack = 1'b0;
        check({tag, "_done_seen"}, got_done, 1'b1);
        check({tag, "_hash_start_cnt"}, hs_cnt, 1);
        check({tag, "_force_cycles"}, fcnt, ack_dly);
        check({tag, "_words_sent"}, idx, used);
        check({tag, "_ready_in_flush"}, ready_bad, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {m_done, m_force}, 2'b00);
        check({tag, "_fail_held"}, m_fail, exp_fail);
        if (!got_done) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic readback(input string tag);
        sb_t s;
        logic [15:0] v;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            rd_istar(s.addr, v);
            check($sformatf("%s_istar%0d", tag, s.addr), v, s.val);
        end
    endtask

    task automatic default_words();
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(64'(32'h00010203 + 32'h04040404 * i));
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; start = 1'b0; h2_we = 1'b0; hash_rd = 1'b0; hvalid = 1'b0; ack = 1'b0;
        is_rd = 1'b0; h2 = '0; h2_addr = '0; hash_addr = '0; hdata = '0; is_addr = '0;
        sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_a_outputs", {a_done, a_fail, a_ready, a_hstart, a_force, a_hdin, a_istar,
                                  a_words}, '0);
        check("reset_c_outputs", {c_done, c_fail, c_ready, c_hstart, c_force, c_istar,
                                  c_words}, '0);
        check("const_inlen", a_inlen, 256);
        check("const_outlen_a", a_outlen, 2048);
        check("const_outlen_b", b_outlen, 128);
        check("const_outlen_c", c_outlen, 256);

        for (int i = 0; i < 8; i++) begin
            h2_ref[i] = 32'hA5A5_0000 ^ (32'h1111_1111 * i);
            @(negedge clk);
            h2_we = 1'b1; h2_addr = 3'(i); h2 = h2_ref[i];
        end
        @(negedge clk);
        h2_we = 1'b0;
        for (int i = 0; i < 8; i += 3) begin
            @(negedge clk);
            hash_addr = 3'(i); hash_rd = 1'b1;
            @(negedge clk);
            hash_rd = 1'b0;
            check($sformatf("h2_read%0d", i), m_hdin, h2_ref[i]);
        end

        default_words();
        run(0, 1'b0, 1, 1'b0, "seq");
        check("seq_latency_le30", last_lat <= 30, 1'b1);
        readback("seq");

        run(0, 1'b1, 5, 1'b0, "toggle");
        readback("toggle");

        sel = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; hvalid = 1'b1; hdata = wq[0];
        repeat (3) @(negedge clk);
        rst = 1'b1; hvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_outputs_zero", {m_done, m_fail, m_ready, m_hstart, m_force, m_hdin,
                                     m_istar, m_words}, '0);
        run(0, 1'b0, 2, 1'b1, "rerun");
        readback("rerun");

        wq.delete();
        wq.push_back(64'hFFC7C8FF);
        for (int i = 0; i < 5; i++) wq.push_back(64'hFFFFFFFF);
        run(1, 1'b0, 1, 1'b0, "reject");
        check("reject_one_accept", sb_q.size(), 1);
        readback("reject");

        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(64'hFFFFFFFF);
        run(1, 1'b0, 3, 1'b0, "budget");
        check("budget_no_writes", sb_q.size(), 0);
        rd_istar(0, v);
        check("budget_istar0_kept", v, mm[1][0]);

        wq.delete();
        wq.push_back(64'h03E8_03E7_0000_FFFF);
        wq.push_back(64'h0001_0002_0003_0004);
        wq.push_back(64'h0005_0006_0007_0008);
        run(2, 1'b0, 1, 1'b0, "wide");
        readback("wide");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/expand_view_challenge_rs.md
Name: expand_view_challenge_rs

Overview:
- Generalised successor of the SDitH ExpandViewChallenge stage.
- Sends the stored 2*SEED_SIZE-bit h2 to the external SHAKE/hash core. Squeezes WORD_W-bit output words and splits each word MSB-first into ELEM_BITS-bit candidates.
- Rejection sampling: a candidate is accepted only if it is < N_PARTIES. Accepted candidates are stored as i_star[0..TAU-1].
- Supports non-power-of-two party counts, wider hash ports, a squeeze budget and a failure flag.

Parameters:
- SEED_SIZE, 128, seed/lambda bits; h2 is 2*SEED_SIZE bits.
- TAU, 17, number of challenge elements to produce.
- WORD_W, 32, hash port width; must be a multiple of 32.
- ELEM_BITS, 8, candidate width; must divide WORD_W; valid range 1..16.
- N_PARTIES, 256, exclusive acceptance bound; valid range 2..2^ELEM_BITS.
- MAX_WORDS, 64, squeeze budget in hash words.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  sync active-high reset
- i_start  in  1  start pulse; ignored unless in IDLE
- o_done  out  1  one-cycle completion pulse
- o_fail  out  1  budget exhausted before TAU accepts; valid with o_done, held until next start
- i_h2  in  32  h2 write data
- i_h2_addr  in  CLOG2(2*SEED_SIZE/32)  h2 word address
- i_h2_wr_en  in  1  h2 write enable
- o_hash_data_in  out  32  h2 word at i_hash_addr; 1-cycle read latency
- i_hash_addr  in  CLOG2(2*SEED_SIZE/32)  hash-core read address; used when i_h2_wr_en=0
- i_hash_rd_en  in  1  hash-core read strobe
- i_hash_data_out  in  WORD_W  squeezed word
- i_hash_data_out_valid  in  1  word valid
- o_hash_data_out_ready  out  1  word accept
- o_hash_input_length  out  32  constant 2*SEED_SIZE
- o_hash_output_length  out  32  constant MAX_WORDS*WORD_W
- o_hash_start  out  1  one-cycle hash start
- o_hash_force_done  out  1  terminate squeeze
- i_hash_force_done_ack  in  1  hash core acknowledges termination
- o_i_star  out  ELEM_BITS  i_star read data; 1-cycle latency
- i_i_star_addr  in  CLOG2(TAU)  i_star read address
- i_i_star_rd_en  in  1  i_star read enable
- o_words_used  out  CLOG2(MAX_WORDS+1)  words consumed in last run

Behaviour:
- Reset values: every output 0; state IDLE; accept count, word count and shift register all 0. Memory contents are not cleared.
- Reset mid-run aborts immediately. No o_done is issued and no force_done is issued; the hash core is reset by the same i_rst.
- E = WORD_W/ELEM_BITS candidates per word.

State machine:
- IDLE: on i_start, register o_hash_start=1 for exactly one cycle. Clear o_fail, o_words_used and the accept count, then go to WAIT.
- WAIT: o_hash_data_out_ready=1 (combinational, this state only). On valid&&ready, load the word into the shift register, increment o_words_used and go to EXTRACT.
- EXTRACT: examines one candidate per cycle, from the top ELEM_BITS of the shift register.
  - If candidate < N_PARTIES, write it to i_star at the accept count, then increment the count.
  - Shift left by ELEM_BITS.
  - Priority 1: if this accept makes count==TAU, go to FLUSH. Remaining candidates are discarded.
  - Priority 2: else if this is candidate E-1 and o_words_used==MAX_WORDS, set o_fail=1 and go to FLUSH.
  - Priority 3: else if this is candidate E-1, go to WAIT.
- FLUSH: hold o_hash_force_done=1 until i_hash_force_done_ack=1, then go to DONE. ready is 0 here.
- DONE: o_done=1 for one cycle, drop force_done, return to IDLE.

Timing and boundaries:
- Throughput is one candidate per cycle, plus 1 cycle per word in WAIT when valid is already high.
- If TAU is reached on the last candidate of the last budgeted word, the result is success: o_fail stays 0.
- i_start while busy is ignored.
- i_star memory address mux: the internal write address is used while busy. External reads are legal only in IDLE; read data while busy is undefined.
- If i_h2_wr_en is asserted during the hash read phase, h2 memory writes take priority over hash-core reads. The hash-core read data is then undefined; the user must not do this.

Test Plan:
- Defaults, words 0x00010203, 0x04050607, … always valid -> i_star[k]=k for k=0..16.
  - o_words_used=5, o_fail=0, one force_done/ack, o_done one cycle after ack.
  - Total latency from o_hash_start to o_done ≤ 30 cycles with ack after 1 cycle.
- N_PARTIES=200, first word 0xFFC7C8FF -> only 0xC7 (199) is stored at i_star[0]; 0xC8 (200) and 0xFF are rejected; the accept count advances by 1.
- MAX_WORDS=4, every word 0xFFFFFFFF, N_PARTIES=200 -> o_words_used=4, o_fail=1, force_done then o_done, no i_star writes.
- Valid toggles every other cycle and ack is delayed 5 cycles -> ready asserted only in WAIT, no word lost or duplicated, force_done held all 5 cycles.
- WORD_W=64, ELEM_BITS=16, N_PARTIES=1000, word 0x03E8_03E7_0000_FFFF -> accepts 999 and 0; rejects 1000 and 65535.
- i_rst asserted mid-EXTRACT, then a fresh i_start -> all outputs 0 after reset; the new run completes normally; a second i_start during the run has no effect.
